// File: rtl/evt_reg_pkg.sv
// evt_reg_pkg: shared constants and types for the two-phase event register.
package evt_reg_pkg;

   localparam int EVT_REG_WIDTH_DEF = 8;
   localparam int EVT_REG_DLY_DEF   = 2;
   localparam int EVT_REG_DLY_MIN   = 1;
   localparam int EVT_REG_DLY_MAX   = 16;

   // Two-phase handshake phase bit
   typedef logic phase_t;

   // True when a request-delay depth is within the supported range
   function automatic bit dly_legal(input int n);
      return (n >= EVT_REG_DLY_MIN) && (n <= EVT_REG_DLY_MAX);
   endfunction

endpackage

// File: rtl/evt_reg_dly.sv
// dly: DLY_CYCLES-deep shift register used to delay the outgoing request
// phase. All stages clear to 0 on synchronous reset.
module dly
   import evt_reg_pkg::*;
#(
   parameter int DLY_CYCLES = EVT_REG_DLY_DEF
) (
   input  logic   clk,
   input  logic   rst,
   input  phase_t in,
   output phase_t out
);

   logic [DLY_CYCLES-1:0] r_sr;

   // Shift the phase in at stage 0; the oldest stage drives the output
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr <= '0;
      end else begin
         r_sr[0] <= in;
         for (int i = 1; i < DLY_CYCLES; i++) begin
            r_sr[i] <= r_sr[i-1];
         end
      end
   end

   assign out = r_sr[DLY_CYCLES-1];

endmodule

// File: rtl/evt_reg.sv
// evt_reg: two-phase bundled-data event register (one pipeline stage of a
// micropipeline built on a synchronous clock).
//
// A single phase bit p is both the upstream acknowledge (Ain) and the source
// of the downstream request (Rout). A capture ("fire") happens when upstream
// has a new event (Rin != p) and downstream has acknowledged the previous one
// (Aout == p). Each fire loads data_out and toggles p.
//
// Optional feature, macro EVT_REG_DLY_EN:
//   defined   -> Rout is p delayed by DLY_CYCLES clocks through a dly instance
//   undefined -> Rout is p directly; DLY_CYCLES is only range-checked
// The fire condition always uses the undelayed p.
module evt_reg
   import evt_reg_pkg::*;
#(
   parameter int WIDTH      = EVT_REG_WIDTH_DEF,
   parameter int DLY_CYCLES = EVT_REG_DLY_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             Rin,
   input  logic             Aout,
   output logic [WIDTH-1:0] data_out,
   output logic             Ain,
   output logic             Rout
);

   phase_t           r_p;
   logic [WIDTH-1:0] r_data;
   logic             w_fire;

   // Reject an unsupported delay depth at elaboration time
   if (!dly_legal(DLY_CYCLES)) begin : g_bad_dly
      $error("evt_reg: DLY_CYCLES must be within 1..16");
   end

   // New upstream event present and previous downstream event acknowledged
   assign w_fire = (Rin != r_p) && (Aout == r_p);

   // Capture data and advance the phase on each fire; reset discards in-flight events
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p    <= 1'b0;
         r_data <= '0;
      end else if (w_fire) begin
         r_p    <= ~r_p;
         r_data <= data_in;
      end
   end

   assign data_out = r_data;
   assign Ain      = r_p;

`ifdef EVT_REG_DLY_EN
   dly #(
      .DLY_CYCLES (DLY_CYCLES)
   ) u_dly (
      .clk (clk),
      .rst (rst),
      .in  (r_p),
      .out (Rout)
   );
`else
   assign Rout = r_p;
`endif

endmodule

// File: tb/tb_evt_reg.sv
// tb_evt_reg: self-checking bench for evt_reg. A behavioural model tracks the
// phase and captured data from the handshake rules and keeps a history of the
// phase to predict Rout; a compare process checks every cycle after reset.
// Directed sequences pin the model with literal values, then randomized
// traffic runs, then a two-stage chain is exercised.
module tb_evt_reg;

   localparam int W = 8;
   localparam int D = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         Rin;
   logic         Aout;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;
   logic         Ain;
   logic         Rout;

   // chain signals
   logic         rst_c;
   logic         Rin_a;
   logic [W-1:0] data_a;
   logic [W-1:0] data_out_a;
   logic         Rout_a;
   logic         Ain_a;
   logic         Ain_b;
   logic [W-1:0] data_out_b;
   logic         Rout_b;
   logic         Aout_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   evt_reg #(.WIDTH(W), .DLY_CYCLES(D)) u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .Rin(Rin), .Aout(Aout),
      .data_out(data_out), .Ain(Ain), .Rout(Rout)
   );

   evt_reg #(.WIDTH(W), .DLY_CYCLES(D)) u_a (
      .clk(clk), .rst(rst_c), .data_in(data_a), .Rin(Rin_a), .Aout(Ain_b),
      .data_out(data_out_a), .Ain(Ain_a), .Rout(Rout_a)
   );

   evt_reg #(.WIDTH(W), .DLY_CYCLES(D)) u_b (
      .clk(clk), .rst(rst_c), .data_in(data_out_a), .Rin(Rout_a), .Aout(Aout_b),
      .data_out(data_out_b), .Ain(Ain_b), .Rout(Rout_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_p: phase; m_data: last captured value; m_hist[k]: phase k edges ago
   logic         m_p    = 1'b0;
   logic [W-1:0] m_data = '0;
   logic         m_hist[$];
   bit           chk_en = 1'b0;

   initial begin
      for (int k = 0; k <= D; k++) m_hist.push_back(1'b0);
   end

   always @(posedge clk) begin
      logic pending, acked;
      if (rst) begin
         m_p    = 1'b0;
         m_data = '0;
         m_hist = {};
         for (int k = 0; k <= D; k++) m_hist.push_back(1'b0);
      end else begin
         pending = (Rin !== m_p);
         acked   = (Aout === m_p);
         if (pending && acked) begin
            m_data = data_in;
            m_p    = !m_p;
         end
         m_hist.push_front(m_p);
         void'(m_hist.pop_back());
      end
   end

   function automatic logic exp_rout();
`ifdef EVT_REG_DLY_EN
      return m_hist[D];
`else
      return m_p;
`endif
   endfunction

   // per-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("data_out", data_out, m_data);
         chk("Ain", Ain, m_p);
         chk("Rout", Rout, exp_rout());
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic         got[$];
      logic [W-1:0] got_d[$];
      logic         seen;
      logic         ack_due;
      int unsigned  r;

      rst = 1'b1; Rin = 1'b1; Aout = 1'b0; data_in = 8'hFF;
      rst_c = 1'b1; Rin_a = 1'b0; data_a = '0; Aout_b = 1'b0;

      // reset for 2 cycles with busy inputs
      repeat (2) @(posedge clk);
      #2;
      chk_en = 1'b1;
      chk("reset_data", data_out, 8'h00);
      chk("reset_Ain", Ain, 1'b0);
      chk("reset_Rout", Rout, 1'b0);
      chk("reset_model", m_data, 8'h00);

      @(negedge clk);
      rst = 1'b0; Rin = 1'b0; Aout = 1'b0; data_in = 8'h00;
      @(negedge clk);

      // single event
      Rin = 1'b1; data_in = 8'h3C;
      @(posedge clk); #2;
      chk("single_data", data_out, 8'h3C);
      chk("single_Ain", Ain, 1'b1);
`ifdef EVT_REG_DLY_EN
      chk("single_Rout_early", Rout, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      chk("single_Rout_late", Rout, 1'b1);
`else
      chk("single_Rout", Rout, 1'b1);
`endif

      // stall: Aout still 0, new event with 55
      @(negedge clk);
      Rin = 1'b0; data_in = 8'h55;
      repeat (3) @(posedge clk);
      #2;
      chk("stall_data", data_out, 8'h3C);
      chk("stall_Ain", Ain, 1'b1);
      @(negedge clk);
      Aout = 1'b1;
      @(posedge clk); #2;
      chk("unstall_data", data_out, 8'h55);
      chk("unstall_Ain", Ain, 1'b0);

      // data hold: no Rin toggle, data_in churns
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         data_in = 8'(i * 37 + 1);
      end
      @(posedge clk); #2;
      chk("hold_data", data_out, 8'h55);
      chk("hold_Ain", Ain, 1'b0);

      // mid-operation reset in the cycle a fire would occur
      @(negedge clk);
      Aout = 1'b0;
      @(negedge clk);
      Rin = 1'b1; data_in = 8'hAA; rst = 1'b1;
      @(posedge clk); #2;
      chk("midrst_data", data_out, 8'h00);
      chk("midrst_Ain", Ain, 1'b0);
      @(negedge clk);
      rst = 1'b0; Rin = 1'b0; Aout = 1'b0;

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         data_in = 8'($urandom);
         r = $urandom_range(0, 99);
         if (r < 3) begin
            rst = 1'b1; Rin = 1'b0; Aout = 1'b0;
         end else begin
            rst = 1'b0;
            if ($urandom_range(0, 99) < 40) Rin = ~Rin;
            r = $urandom_range(0, 99);
            if (r < 50)      Aout = Rout;
            else if (r < 55) Aout = ~Aout;
         end
      end
      @(negedge clk);
      rst = 1'b0;

      // two-stage chain, downstream acknowledge one cycle after each request
      @(negedge clk);
      @(negedge clk);
      rst_c = 1'b0;
      seen = 1'b0;
      ack_due = 1'b0;
      fork
         begin
            for (int k = 1; k <= 4; k++) begin
               for (int t = 0; t < 100 && Ain_a !== Rin_a; t++) @(negedge clk);
               chk("chain_accept", Ain_a, Rin_a);
               data_a = 8'(k);
               Rin_a = ~Rin_a;
               @(negedge clk);
            end
         end
         begin
            for (int t = 0; t < 300 && (got_d.size() < 4 || ack_due); t++) begin
               @(negedge clk);
               if (ack_due) begin
                  Aout_b = seen;
                  ack_due = 1'b0;
               end
               if (Rout_b !== seen) begin
                  got_d.push_back(data_out_b);
                  got.push_back(Rout_b);
                  seen = Rout_b;
                  ack_due = 1'b1;
               end
            end
         end
      join
      repeat (20) begin
         @(negedge clk);
         if (Rout_b !== seen) begin
            got_d.push_back(data_out_b);
            seen = Rout_b;
         end
      end
      chk("chain_count", got_d.size(), 4);
      for (int k = 0; k < got_d.size() && k < 4; k++) begin
         chk($sformatf("chain_val%0d", k), got_d[k], 8'(k + 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/evt_reg.md
EVT_REG -- requirements
Module: evt_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data path width in bits.
REQ-002 The block SHALL have parameter DLY_CYCLES, default 2, giving the request delay in clock cycles; legal values are 1..16.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-005 The block SHALL have port data_in, input, WIDTH bits, the upstream bundled data.
REQ-006 The block SHALL have port Rin, input, 1 bit, the upstream request (two-phase: every toggle is one event).
REQ-007 The block SHALL have port Aout, input, 1 bit, the downstream acknowledge (two-phase).
REQ-008 The block SHALL have port data_out, output, WIDTH bits, the registered data.
REQ-009 The block SHALL have port Ain, output, 1 bit, the upstream acknowledge (two-phase).
REQ-010 The block SHALL have port Rout, output, 1 bit, the downstream request (two-phase).

Function
REQ-011 The block SHALL keep one phase bit p; Ain SHALL equal p at all times.
REQ-012 The block SHALL define fire = (Rin != p) && (Aout == p); fire means a new upstream event is present and the previous downstream event has been acknowledged.
REQ-013 On a clock edge with fire=1, the block SHALL load data_out <= data_in and toggle p; with fire=0, data_out and p SHALL hold.
REQ-014 Latency from a Rin toggle (with the handshake free) to the Ain toggle and the data_out update SHALL be exactly 1 cycle.
REQ-015 The block SHALL hold data_out stable from one capture to the next, regardless of data_in changes.
REQ-016 A Rin toggle while Aout != p SHALL stall (no capture, Ain unchanged) until Aout == p; the block SHALL then fire on the next edge.
REQ-017 A Rin toggle back to p before a capture (an event withdrawn) SHALL cause no capture; this is legal but outside protocol.
REQ-018 If Aout toggles when Aout already equals p (a spurious acknowledge), the block SHALL stall until Aout returns to p; the block SHALL not detect this as an error.
REQ-019 The block SHALL perform at most one capture per cycle; back-to-back events SHALL sustain one event per 2 cycles when the downstream acknowledges in 1 cycle.

Reset
REQ-020 While rst=1 at a clock edge, the block SHALL set p=0, data_out=0, all delay-line stages=0, so that Ain=0 and Rout=0.
REQ-021 Reset SHALL override fire; events in flight at reset SHALL be discarded.
REQ-022 After reset, the environment SHALL drive Rin=0 and Aout=0 before issuing events.

Configuration
REQ-023 With macro EVT_REG_DLY_EN defined, Rout SHALL equal p delayed by exactly DLY_CYCLES clock cycles through the delay line.
REQ-024 With EVT_REG_DLY_EN undefined, Rout SHALL equal p directly, the delay line SHALL not be instantiated, and DLY_CYCLES SHALL be ignored.
REQ-025 In both configurations, the fire condition SHALL compare Aout against the undelayed p.

Structure
REQ-026 Shared package evt_reg_pkg SHALL hold the constants EVT_REG_WIDTH_DEF=8 and EVT_REG_DLY_DEF=2, and the typedef phase_t (1-bit logic).
REQ-027 The request delay SHALL be a sub-module named dly: a DLY_CYCLES-deep shift register with inputs clk, rst, in and output out, which resets to 0.
REQ-028 Two evt_reg instances SHALL chain with the upstream Rout to the downstream Rin and the downstream Ain to the upstream Aout, with no glue logic.

Verification
REQ-029 Reset test: rst=1 for 2 cycles with data_in=8'hFF and Rin=1 -> data_out=8'h00, Ain=0, Rout=0.
REQ-030 Single event test: Rin 0->1 with data_in=8'h3C and Aout=0 -> after 1 cycle, data_out=8'h3C and Ain=1; Rout=1 after 1 cycle (macro off) or after 1+2 cycles (macro on).
REQ-031 Stall test: after the first event, hold Aout=0 and toggle Rin 1->0 with data_in=8'h55 -> data_out stays 8'h3C and Ain stays 1; raising Aout=1 -> the next cycle gives data_out=8'h55 and Ain=0.
REQ-032 Data hold test: with no Rin toggle, change data_in every cycle for 10 cycles -> data_out and Ain are unchanged.
REQ-033 Chain test: two instances with a testbench acknowledge after 1 cycle, feeding 4 events 8'h01..8'h04 -> all 4 values appear in order at the second data_out, with no loss or duplication.
REQ-034 Mid-operation reset test: assert rst in the cycle a fire would occur -> p=0 and data_out=0, and no capture occurs.
